// File: rtl/cuda_warp_regfile.sv
// Warp register file: two banks selected by addr[0], dual read with conflict stall.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module cuda_warp_regfile #(
    parameter int LANES    = 32,
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
    input  logic [LANES-1:0]            wr_mask,
    input  logic [LANES*DATA_W-1:0]     wr_data,
    input  logic [LANES-1:0]            wr_is_float,
    input  logic                        rd_valid,
    output logic                        rd_ready,
    input  logic [$clog2(NUM_REGS)-1:0] rd_addr1,
    input  logic [$clog2(NUM_REGS)-1:0] rd_addr2,
    output logic                        rsp_valid,
    output logic [LANES*DATA_W-1:0]     rsp_data1,
    output logic [LANES*DATA_W-1:0]     rsp_data2,
    output logic [LANES-1:0]            rsp_is_float1,
    output logic [LANES-1:0]            rsp_is_float2
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int NB = NUM_REGS / 2;
    localparam int DW = LANES * DATA_W;

    typedef enum logic {IDLE, SECOND} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DW-1:0]     r_data [2][NB];
    logic [LANES-1:0]  r_tag  [2][NB];
    logic [AW-1:0]     r_addr2;
    logic [DW-1:0]     r_hold_data;
    logic [LANES-1:0]  r_hold_tag;

    logic [AW-1:0]     w_baddr [2];
    logic [DW-1:0]     w_bdata [2];
    logic [LANES-1:0]  w_btag  [2];
    logic [AW-1:0]     w_p2_addr;
    logic              w_accept;
    logic              w_conflict;
    logic [DW-1:0]     w_rd1;
    logic [DW-1:0]     w_rd2;
    logic [LANES-1:0]  w_rt1;
    logic [LANES-1:0]  w_rt2;

    assign rd_ready   = (r_state == IDLE);
    assign w_accept   = rd_valid && rd_ready;
    assign w_conflict = (rd_addr1[0] == rd_addr2[0]) && (rd_addr1 != rd_addr2);
    assign w_p2_addr  = (r_state == SECOND) ? r_addr2 : rd_addr2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < NB; e++) begin
                    r_data[b][e] <= '0;
                    r_tag[b][e]  <= '0;
                end
            end
        end else if (wr_en && wr_addr != '0) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_mask[i]) begin
                    r_data[wr_addr[0]][wr_addr[AW-1:1]][i*DATA_W +: DATA_W] <=
                        wr_data[i*DATA_W +: DATA_W];
                    r_tag[wr_addr[0]][wr_addr[AW-1:1]][i] <= wr_is_float[i];
                end
            end
        end
    end

    // Port 1 claims its bank last so it wins when both ports hit one bank.
    always_comb begin
        w_baddr[0] = '0;
        w_baddr[1] = '0;
        if (r_state == SECOND) begin
            w_baddr[r_addr2[0]] = r_addr2;
        end else begin
            w_baddr[rd_addr2[0]] = rd_addr2;
            w_baddr[rd_addr1[0]] = rd_addr1;
        end
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_bdata[b] = r_data[b][w_baddr[b][AW-1:1]];
            w_btag[b]  = r_tag[b][w_baddr[b][AW-1:1]];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && wr_addr == w_baddr[b]) begin
                for (int i = 0; i < LANES; i++) begin
                    if (wr_mask[i]) begin
                        w_bdata[b][i*DATA_W +: DATA_W] = wr_data[i*DATA_W +: DATA_W];
                        w_btag[b][i] = wr_is_float[i];
                    end
                end
            end
`endif
            if (w_baddr[b] == '0) begin
                w_bdata[b] = '0;
                w_btag[b]  = '0;
            end
        end
    end

    assign w_rd1 = w_bdata[rd_addr1[0]];
    assign w_rt1 = w_btag[rd_addr1[0]];
    assign w_rd2 = w_bdata[w_p2_addr[0]];
    assign w_rt2 = w_btag[w_p2_addr[0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:   if (w_accept && w_conflict) w_next = SECOND;
            SECOND: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid     <= 1'b0;
            rsp_data1     <= '0;
            rsp_data2     <= '0;
            rsp_is_float1 <= '0;
            rsp_is_float2 <= '0;
            r_addr2       <= '0;
            r_hold_data   <= '0;
            r_hold_tag    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (r_state == SECOND) begin
                rsp_valid     <= 1'b1;
                rsp_data1     <= r_hold_data;
                rsp_is_float1 <= r_hold_tag;
                rsp_data2     <= w_rd2;
                rsp_is_float2 <= w_rt2;
            end else if (w_accept && w_conflict) begin
                r_hold_data <= w_rd1;
                r_hold_tag  <= w_rt1;
                r_addr2     <= rd_addr2;
            end else if (w_accept) begin
                rsp_valid     <= 1'b1;
                rsp_data1     <= w_rd1;
                rsp_is_float1 <= w_rt1;
                rsp_data2     <= w_rd2;
                rsp_is_float2 <= w_rt2;
            end
        end
    end
endmodule

// File: tb/tb_cuda_warp_regfile.sv
// Scoreboard bench for cuda_warp_regfile: directed reads/writes, queued expectations.
module tb_cuda_warp_regfile;
    localparam int L = 4;
    localparam int D = 16;
    localparam int N = 8;
    localparam int W = L * D;

    typedef struct {
        int          cyc;
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        logic [L-1:0] t1;
        logic [L-1:0] t2;
    } exp_t;

    logic         clk = 0;
    logic         rst = 1;
    logic         wr_en = 0;
    logic [2:0]   wr_addr = '0;
    logic [L-1:0] wr_mask = '0;
    logic [W-1:0] wr_data = '0;
    logic [L-1:0] wr_is_float = '0;
    logic         rd_valid = 0;
    logic         rd_ready;
    logic [2:0]   rd_addr1 = '0;
    logic [2:0]   rd_addr2 = '0;
    logic         rsp_valid;
    logic [W-1:0] rsp_data1, rsp_data2;
    logic [L-1:0] rsp_is_float1, rsp_is_float2;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    cuda_warp_regfile #(.LANES(L), .NUM_REGS(N), .DATA_W(D)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask),
        .wr_data(wr_data), .wr_is_float(wr_is_float),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rsp_valid(rsp_valid),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
        .rsp_is_float1(rsp_is_float1), .rsp_is_float2(rsp_is_float2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] rep(input logic [D-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < L; i++) r[i*D +: D] = v;
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (rsp_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp cyc=%0d actual=valid required=none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (cyc != e.cyc || rsp_data1 !== e.d1 || rsp_data2 !== e.d2 ||
                    rsp_is_float1 !== e.t1 || rsp_is_float2 !== e.t2) begin
                    errors++;
                    $display("FAIL rsp actual=%0d %h %h %h %h required=%0d %h %h %h %h",
                             cyc, rsp_data1, rsp_data2, rsp_is_float1, rsp_is_float2,
                             e.cyc, e.d1, e.d2, e.t1, e.t2);
                end
            end
        end
    end

    // Entered and left at a negedge; consecutive calls issue back-to-back.
    task automatic do_read(input logic [2:0] a1, input logic [2:0] a2, input int lat,
                           input logic [W-1:0] d1, input logic [W-1:0] d2,
                           input logic [L-1:0] t1, input logic [L-1:0] t2);
        rd_valid = 1;
        rd_addr1 = a1;
        rd_addr2 = a2;
        chk("ready_idle", W'(rd_ready), W'(1));
        q.push_back('{cyc + lat, d1, d2, t1, t2});
        @(negedge clk);
        rd_valid = 0;
        if (lat == 2) begin
            chk("ready_second", W'(rd_ready), W'(0));
            @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [L-1:0] m,
                            input logic [W-1:0] d, input logic [L-1:0] t);
        wr_en = 1;
        wr_addr = a;
        wr_mask = m;
        wr_data = d;
        wr_is_float = t;
        @(negedge clk);
        wr_en = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] lanes3;
        logic [W-1:0] r7new;
        logic [W-1:0] r7byp;
        lanes3 = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
        r7new  = {16'h0011, 16'h0011, 16'h0011, 16'h0022};
`ifdef REGFILE_BYPASS_EN
        r7byp = r7new;
`else
        r7byp = rep(16'h0011);
`endif
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_ready", W'(rd_ready), W'(1));
        chk("rst_valid", W'(rsp_valid), W'(0));
        chk("rst_data1", rsp_data1, '0);
        chk("rst_tags", W'({rsp_is_float1, rsp_is_float2}), W'(0));

        do_read(3'd5, 3'd6, 1, '0, '0, '0, '0);

        do_write(3'd3, 4'hF, lanes3, 4'b0001);
        do_read(3'd3, 3'd0, 1, lanes3, '0, 4'b0001, '0);

        do_write(3'd4, 4'hF, rep(16'hAAAA), 4'h0);
        do_write(3'd6, 4'hF, rep(16'hBBBB), 4'h0);
        do_read(3'd4, 3'd6, 2, rep(16'hAAAA), rep(16'hBBBB), '0, '0);

        do_write(3'd7, 4'hF, rep(16'h0011), 4'h0);
        wr_en = 1;
        wr_addr = 3'd7;
        wr_mask = 4'h1;
        wr_data = rep(16'h0022);
        wr_is_float = 4'h0;
        do_read(3'd7, 3'd2, 1, r7byp, '0, '0, '0);
        wr_en = 0;
        do_read(3'd7, 3'd2, 1, r7new, '0, '0, '0);

        do_read(3'd3, 3'd4, 1, lanes3, rep(16'hAAAA), 4'b0001, '0);
        do_read(3'd7, 3'd6, 1, r7new, rep(16'hBBBB), '0, '0);
        do_read(3'd4, 3'd4, 1, rep(16'hAAAA), rep(16'hAAAA), '0, '0);

        do_write(3'd0, 4'hF, rep(16'hFFFF), 4'hF);
        do_read(3'd0, 3'd0, 1, '0, '0, '0, '0);

        rd_valid = 1;
        rd_addr1 = 3'd4;
        rd_addr2 = 3'd6;
        @(negedge clk);
        rd_valid = 0;
        chk("pre_rst_second", W'(rd_ready), W'(0));
        rst = 1;
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        chk("post_rst_ready", W'(rd_ready), W'(1));
        chk("post_rst_data1", rsp_data1, '0);
        chk("post_rst_data2", rsp_data2, '0);
        do_read(3'd4, 3'd6, 2, '0, '0, '0, '0);
        do_read(3'd3, 3'd7, 2, '0, '0, '0, '0);

        repeat (4) @(negedge clk);
        chk("queue_drained", W'(q.size()), W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
